// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [15:0] CrcPoly = 16'h1021;
  localparam logic [15:0] CrcInit = 16'hFFFF;

  function automatic logic state_is_busy(input state_e st);
    return (st == StWait) || (st == StShift);
  endfunction

endpackage

// File: rtl/ccff_crc16_step.sv
// One-bit combinational CRC-16-CCITT update, MSB-first.
module ccff_crc16_step
  import ccff_loader_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic        data_i,
  output logic [15:0] crc_o
);

  logic feedback;

  assign feedback = crc_i[15] ^ data_i;
  assign crc_o    = {crc_i[14:0], 1'b0} ^ (feedback ? CrcPoly : 16'h0000);

endmodule

// File: rtl/ccff_loader.sv
// Streams bitstream words LSB-first into a configuration flip-flop chain.
// Optional running CRC over shifted bits is enabled by defining CCFF_LOADER_CRC_EN.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 128,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       crc
);

  localparam int unsigned    CntW     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned    IdxW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CntW-1:0] ChainEnd = CntW'(CHAIN_LEN);
  localparam logic [IdxW-1:0] WordEnd  = IdxW'(WORD_W - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic              chain_end;
  logic              word_end;

  assign cnt_inc   = cnt_q + 1'b1;
  assign chain_end = (cnt_inc == ChainEnd);
  assign word_end  = (idx_q == WordEnd);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cfg_ready = 1'b0;
    shift_en  = 1'b0;

    if (abort) begin
      // Abort overrides everything: no shift and no word accepted this cycle.
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StWait;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        StWait: begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            word_d  = cfg_data;
            idx_d   = '0;
            state_d = StShift;
          end
        end
        StShift: begin
          shift_en = 1'b1;
          cnt_d    = cnt_inc;
          if (chain_end) begin
            // High bits of a partial final word are simply dropped.
            state_d = StDone;
          end else if (word_end) begin
            // Accept the next word on the last bit so shifting has no bubble.
            cfg_ready = 1'b1;
            idx_d     = '0;
            if (cfg_valid) begin
              word_d = cfg_data;
            end else begin
              state_d = StWait;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ccff_head = shift_en & word_q[idx_q];
  assign busy      = state_is_busy(state_q);
  assign done      = (state_q == StDone);

`ifdef CCFF_LOADER_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;
  logic        crc_clr;

  assign crc_clr = start & ~abort & ((state_q == StIdle) | (state_q == StDone));

  ccff_crc16_step u_crc_step (
    .crc_i  (crc_q),
    .data_i (ccff_head),
    .crc_o  (crc_next)
  );

  always_comb begin
    crc_d = crc_q;
    if (crc_clr) begin
      crc_d = CrcInit;
    end else if (shift_en) begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      crc_q <= CrcInit;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: 128-bit and 40-bit chains against a bit-queue model.
module tb_ccff_loader;

  logic        prog_clk = 1'b0;
  logic        pReset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_data = 32'h0;
  logic        sel = 1'b0;

  logic        rdy_a, head_a, sh_a, busy_a, done_a;
  logic        rdy_b, head_b, sh_b, busy_b, done_b;
  logic [15:0] crc_a, crc_b;
  logic        rdy_w, head_w, sh_w, busy_w, done_w;
  logic [15:0] crc_w;

`ifdef CCFF_LOADER_CRC_EN
  localparam logic [15:0] CrcRst = 16'hFFFF;
`else
  localparam logic [15:0] CrcRst = 16'h0000;
`endif

  ccff_loader #(.CHAIN_LEN(128), .WORD_W(32)) dut (
    .prog_clk (prog_clk), .pReset (pReset), .start (start), .abort (abort),
    .cfg_data (cfg_data), .cfg_valid (cfg_valid), .cfg_ready (rdy_a),
    .ccff_head (head_a), .shift_en (sh_a), .busy (busy_a), .done (done_a), .crc (crc_a)
  );

  ccff_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut40 (
    .prog_clk (prog_clk), .pReset (pReset), .start (start), .abort (abort),
    .cfg_data (cfg_data), .cfg_valid (cfg_valid), .cfg_ready (rdy_b),
    .ccff_head (head_b), .shift_en (sh_b), .busy (busy_b), .done (done_b), .crc (crc_b)
  );

  assign rdy_w  = sel ? rdy_b  : rdy_a;
  assign head_w = sel ? head_b : head_a;
  assign sh_w   = sel ? sh_b   : sh_a;
  assign busy_w = sel ? busy_b : busy_a;
  assign done_w = sel ? done_b : done_a;
  assign crc_w  = sel ? crc_b  : crc_a;

  always #5 prog_clk = ~prog_clk;

  int checks = 0;
  int errors = 0;

  // Monitor: records every shifted bit and the cycle it was shifted in.
  bit          mon_en = 1'b0;
  bit          got_q[$];
  int          cyc_q[$];
  int          n_shift = 0;
  int          head_bad = 0;
  int          cyc = 0;

  always @(negedge prog_clk) begin
    if (mon_en) begin
      if (sh_w === 1'b1) begin
        got_q.push_back(head_w);
        cyc_q.push_back(cyc);
        n_shift++;
      end else if (head_w !== 1'b0) begin
        head_bad++;
      end
    end
    cyc++;
  end

  logic [31:0] wq[$];
  bit          exp_q[$];

  function automatic void build_exp(input int len);
    exp_q.delete();
    foreach (wq[w]) begin
      for (int b = 0; b < 32; b++) begin
        if (exp_q.size() < len) exp_q.push_back(((wq[w] >> b) & 32'h1) != 0);
      end
    end
  endfunction

  function automatic int bit_diff(input int idx0, input int len);
    int d = 0;
    for (int i = 0; i < len; i++) begin
      if (idx0 + i >= got_q.size()) d++;
      else if (got_q[idx0 + i] != exp_q[i]) d++;
    end
    return d;
  endfunction

  function automatic logic [15:0] crc_ref(input int len);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      if ((c[15] ^ exp_q[i]) != 1'b0) c = (c << 1) ^ 16'h1021;
      else c = c << 1;
    end
`ifdef CCFF_LOADER_CRC_EN
    return c;
`else
    return (c == 16'h0) ? 16'h1 : 16'h0;
`endif
  endfunction

  // Feeds wq into the selected DUT. Cycle 0 is the cycle start is high.
  // done_cyc: cycle in which done was first seen; -1 on timeout; -2 if stopped at stop_shift.
  task automatic run_load(input int gap_word, input int gap_len, input int stop_shift,
                          input int busy_start, output int done_cyc, output int extra_rdy,
                          output int idx0, output int sh0);
    int ptr = 0;
    int gap_cnt = 0;
    logic rdy_now;
    idx0 = got_q.size();
    sh0 = n_shift;
    done_cyc = -1;
    extra_rdy = 0;
    @(negedge prog_clk); #1;
    start = 1'b1;
    cfg_valid = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge prog_clk); #1;
      start = 1'b0;
      if (done_w === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (stop_shift >= 0 && n_shift - sh0 == stop_shift) begin
        done_cyc = -2;
        break;
      end
      if (busy_start >= 0 && n_shift - sh0 == busy_start) start = 1'b1;
      rdy_now = rdy_w;
      if (ptr >= wq.size()) begin
        cfg_valid = 1'b0;
        if (rdy_now === 1'b1) extra_rdy++;
      end else if (ptr == gap_word && rdy_now === 1'b1 && gap_cnt < gap_len) begin
        cfg_valid = 1'b0;
        gap_cnt++;
      end else begin
        cfg_valid = 1'b1;
        cfg_data = wq[ptr];
        if (rdy_now === 1'b1) ptr++;
      end
    end
    if (done_cyc != -2) cfg_valid = 1'b0;
  endtask

  task automatic set_std_words();
    wq.delete();
    wq.push_back(32'h0000_0001);
    wq.push_back(32'h8000_0000);
    wq.push_back(32'hA5A5_A5A5);
    wq.push_back(32'hFFFF_FFFF);
  endtask

  task automatic test_reset();
    #2 pReset = 1'b1;
    #2 mon_en = 1'b1;
    checks++;
    if ({rdy_a, sh_a, head_a, busy_a, done_a, crc_a} !== {5'b0, CrcRst}) begin
      errors++;
      $display("FAIL reset_outputs got %b_%h want 00000_%h",
               {rdy_a, sh_a, head_a, busy_a, done_a}, crc_a, CrcRst);
    end
    @(negedge prog_clk); #1;
    pReset = 1'b0;
    start = 1'b1;
    @(negedge prog_clk); #1;
    start = 1'b0;
    checks++;
    if ({busy_a, rdy_a} !== 2'b11) begin
      errors++;
      $display("FAIL first_start got busy=%b rdy=%b want 1 1", busy_a, rdy_a);
    end
    abort = 1'b1;
    @(negedge prog_clk); #1;
    abort = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_from_wait got busy=%b want 0", busy_a);
    end
  endtask

  task automatic test_directed();
    int dc, er, i0, s0;
    sel = 1'b0;
    set_std_words();
    build_exp(128);
    run_load(-1, 0, -1, -1, dc, er, i0, s0);
    checks++;
    if (n_shift - s0 != 128) begin
      errors++;
      $display("FAIL dir_count got %0d want 128", n_shift - s0);
    end
    checks++;
    if (bit_diff(i0, 128) != 0) begin
      errors++;
      $display("FAIL dir_bits got %0d wrong bits want 0", bit_diff(i0, 128));
    end
    checks++;
    if (got_q.size() < i0 + 128 || got_q[i0] != 1'b1 || got_q[i0 + 63] != 1'b1) begin
      errors++;
      $display("FAIL dir_bit0_63 got missing-or-zero want both 1");
    end
    checks++;
    if (got_q.size() > i0 && cyc_q[$] - cyc_q[i0] + 1 != 128) begin
      errors++;
      $display("FAIL dir_contig got span %0d want 128", cyc_q[$] - cyc_q[i0] + 1);
    end
    checks++;
    if (dc != 130) begin
      errors++;
      $display("FAIL dir_done_cycle got %0d want 130", dc);
    end
    // done holds and valid is ignored in DONE
    cfg_valid = 1'b1;
    repeat (3) @(negedge prog_clk);
    #1;
    checks++;
    if ({done_w, busy_w, rdy_w, sh_w} !== 4'b1000 || n_shift - s0 != 128) begin
      errors++;
      $display("FAIL dir_done_hold got %b shifts %0d want 1000 128",
               {done_w, busy_w, rdy_w, sh_w}, n_shift - s0);
    end
    checks++;
    if (crc_w !== crc_ref(128)) begin
      errors++;
      $display("FAIL dir_crc got %h want %h", crc_w, crc_ref(128));
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_valid_gap();
    int dc, er, i0, s0;
    sel = 1'b0;
    set_std_words();
    build_exp(128);
    run_load(2, 5, -1, -1, dc, er, i0, s0);
    checks++;
    if (n_shift - s0 != 128 || bit_diff(i0, 128) != 0) begin
      errors++;
      $display("FAIL gap_bits got %0d shifts %0d wrong want 128 0",
               n_shift - s0, bit_diff(i0, 128));
    end
    checks++;
    if (got_q.size() > i0 && cyc_q[$] - cyc_q[i0] + 1 - 128 != 5) begin
      errors++;
      $display("FAIL gap_len got %0d want 5", cyc_q[$] - cyc_q[i0] + 1 - 128);
    end
    checks++;
    if (dc != 135) begin
      errors++;
      $display("FAIL gap_done_cycle got %0d want 135", dc);
    end
  endtask

  task automatic test_short_chain();
    int dc, er, i0, s0;
    bit last8[8];
    sel = 1'b1;
    wq.delete();
    wq.push_back(32'hFFFF_FFFF);
    wq.push_back(32'h0000_00F0);
    build_exp(40);
    run_load(-1, 0, -1, -1, dc, er, i0, s0);
    checks++;
    if (n_shift - s0 != 40 || bit_diff(i0, 40) != 0) begin
      errors++;
      $display("FAIL short_bits got %0d shifts %0d wrong want 40 0",
               n_shift - s0, bit_diff(i0, 40));
    end
    for (int i = 0; i < 8; i++) last8[i] = (got_q.size() > i0 + 32 + i) ? got_q[i0 + 32 + i] : 1'b0;
    checks++;
    if ({last8[0], last8[1], last8[2], last8[3], last8[4], last8[5], last8[6], last8[7]}
        !== 8'b0000_1111) begin
      errors++;
      $display("FAIL short_last8 got %b want 00001111",
               {last8[0], last8[1], last8[2], last8[3], last8[4], last8[5], last8[6], last8[7]});
    end
    checks++;
    if (er != 0) begin
      errors++;
      $display("FAIL short_no_ready got %0d ready cycles want 0", er);
    end
    checks++;
    if (dc != 42) begin
      errors++;
      $display("FAIL short_done_cycle got %0d want 42", dc);
    end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    int dc, er, i0, s0;
    sel = 1'b0;
    set_std_words();
    build_exp(128);
    run_load(-1, 0, 50, -1, dc, er, i0, s0);
    abort = 1'b1;
    #1;
    checks++;
    if ({sh_w, rdy_w, head_w} !== 3'b000) begin
      errors++;
      $display("FAIL abort_cycle got sh/rdy/head %b want 000", {sh_w, rdy_w, head_w});
    end
    @(negedge prog_clk); #1;
    abort = 1'b0;
    cfg_valid = 1'b0;
    checks++;
    if ({busy_w, done_w, sh_w} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle got busy/done/sh %b want 000", {busy_w, done_w, sh_w});
    end
    run_load(-1, 0, -1, -1, dc, er, i0, s0);
    checks++;
    if (n_shift - s0 != 128 || bit_diff(i0, 128) != 0 || dc != 130) begin
      errors++;
      $display("FAIL abort_reload got %0d shifts %0d wrong done %0d want 128 0 130",
               n_shift - s0, bit_diff(i0, 128), dc);
    end
  endtask

  task automatic test_reset_midload();
    int dc, er, i0, s0;
    sel = 1'b0;
    set_std_words();
    build_exp(128);
    run_load(-1, 0, 70, -1, dc, er, i0, s0);
    pReset = 1'b1;
    #1;
    checks++;
    if ({rdy_w, sh_w, head_w, busy_w, done_w, crc_w} !== {5'b0, CrcRst}) begin
      errors++;
      $display("FAIL midload_reset got %b_%h want 00000_%h",
               {rdy_w, sh_w, head_w, busy_w, done_w}, crc_w, CrcRst);
    end
    @(negedge prog_clk); #1;
    pReset = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic test_back_to_back_start();
    int dc, er, i0, s0;
    sel = 1'b0;
    set_std_words();
    build_exp(128);
    run_load(-1, 0, -1, 20, dc, er, i0, s0);
    checks++;
    if (n_shift - s0 != 128 || bit_diff(i0, 128) != 0 || dc != 130) begin
      errors++;
      $display("FAIL busy_start got %0d shifts %0d wrong done %0d want 128 0 130",
               n_shift - s0, bit_diff(i0, 128), dc);
    end
  endtask

  task automatic test_random();
    int dc, er, i0, s0, gw, gl;
    sel = 1'b0;
    for (int it = 0; it < 5; it++) begin
      wq.delete();
      for (int w = 0; w < 4; w++) wq.push_back($urandom);
      build_exp(128);
      gw = $urandom_range(1, 3);
      gl = $urandom_range(1, 6);
      run_load(gw, gl, -1, -1, dc, er, i0, s0);
      checks++;
      if (n_shift - s0 != 128 || bit_diff(i0, 128) != 0) begin
        errors++;
        $display("FAIL rand%0d_bits got %0d shifts %0d wrong want 128 0",
                 it, n_shift - s0, bit_diff(i0, 128));
      end
      checks++;
      if (dc != 130 + gl || (got_q.size() > i0 && cyc_q[$] - cyc_q[i0] + 1 != 128 + gl)) begin
        errors++;
        $display("FAIL rand%0d_timing got done %0d want %0d", it, dc, 130 + gl);
      end
      checks++;
      if (crc_w !== crc_ref(128)) begin
        errors++;
        $display("FAIL rand%0d_crc got %h want %h", it, crc_w, crc_ref(128));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_valid_gap();
    test_short_chain();
    test_abort();
    test_reset_midload();
    test_back_to_back_start();
    test_random();
    checks++;
    if (head_bad != 0) begin
      errors++;
      $display("FAIL head_idle got %0d nonzero cycles want 0", head_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 128: number of configuration bits in the target chain (range 1..65535).
REQ-002 SHALL have parameter WORD_W, default 32: width of the bitstream input word.
REQ-003 SHALL have port prog_clk, input, 1, the single clock for all state.
REQ-004 SHALL have port pReset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a chain load.
REQ-006 SHALL have port abort, input, 1, terminates a load in progress.
REQ-007 SHALL have port cfg_data, input, WORD_W, a bitstream word, shifted LSB first.
REQ-008 SHALL have port cfg_valid, input, 1, cfg_data is valid.
REQ-009 SHALL have port cfg_ready, output, 1, the loader accepts cfg_data this cycle.
REQ-010 SHALL have port ccff_head, output, 1, serial bit into the configuration chain.
REQ-011 SHALL have port shift_en, output, 1, the chain shifts on this prog_clk edge.
REQ-012 SHALL have port busy, output, 1, a load is in progress.
REQ-013 SHALL have port done, output, 1, the last load completed; held until next start or reset.
REQ-014 SHALL have port crc, output, 16, CRC over the shifted bits (see Configuration).

Function
REQ-015 SHALL implement states IDLE, WAIT, SHIFT and DONE.
REQ-016 IDLE/DONE: start=1 -> WAIT next cycle; bit counter cleared; done cleared.
REQ-017 WAIT: cfg_ready=1; on cfg_valid&cfg_ready, word captured, -> SHIFT next cycle.
REQ-018 SHIFT: shift_en=1 every cycle; ccff_head = current word bit k, k=0..WORD_W-1; bit counter +1 per cycle.
REQ-019 SHIFT, last bit of word, bits remaining: cfg_ready=1 combinationally; word accepted -> SHIFT continues with bit 0 of the new word, no bubble; otherwise -> WAIT.
REQ-020 SHIFT, bit counter reaching CHAIN_LEN: -> DONE next cycle; remaining high bits of a partial final word discarded; cfg_ready=0 in that cycle.
REQ-021 Total shift_en-high cycles per completed load SHALL equal CHAIN_LEN exactly.
REQ-022 busy=1 in WAIT and SHIFT only; done=1 in DONE only.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort SHALL take priority over all other inputs: -> IDLE next cycle, shift_en=0, done=0, no word accepted that cycle.
REQ-025 cfg_ready SHALL be 0 in IDLE and DONE; cfg_valid there is ignored.
REQ-026 ccff_head SHALL be 0 whenever shift_en=0.

Reset
REQ-027 pReset asserted SHALL immediately force IDLE, cfg_ready=0, shift_en=0, ccff_head=0, busy=0, done=0, crc=16'hFFFF, counters 0, including mid-load.
REQ-028 First start SHALL be honoured on the first prog_clk edge after pReset deasserts.

Configuration
REQ-029 With CCFF_LOADER_CRC_EN defined, crc SHALL be CRC-16-CCITT (poly 0x1021, MSB-first update, init 0xFFFF at start), updated with ccff_head on each shift_en cycle, and held in DONE.
REQ-030 Without CCFF_LOADER_CRC_EN, crc SHALL be constant 16'h0000 and no CRC logic SHALL be present.

Structure
REQ-031 A shared package ccff_loader_pkg SHALL hold the state enum, CRC polynomial and init constants.
REQ-032 The CRC update SHALL be a sub-module ccff_crc16_step (one-bit combinational update).
REQ-033 Bit counter width SHALL be $clog2(CHAIN_LEN+1).

Verification
REQ-034 CHAIN_LEN=128, four words 0x0000_0001, 0x8000_0000, 0xA5A5_A5A5, 0xFFFF_FFFF, cfg_valid always high -> 128 contiguous shift_en cycles; head bits 0 and 63 are 1; done at cycle 130 after start.
REQ-035 Same words, cfg_valid dropped 5 cycles before word 3 -> shift_en gap of 5 cycles; head sequence unchanged; done still set.
REQ-036 CHAIN_LEN=40, words 0xFFFF_FFFF, 0x0000_00F0 -> 40 shifts; last 8 head bits 0,0,0,0,1,1,1,1; cfg_ready never reasserted after word 2.
REQ-037 abort at shift 50 of 128 -> IDLE next cycle, shift_en=0, done=0; new start reloads all 128 bits.
REQ-038 pReset pulsed at shift 70 -> all outputs at reset values within the same cycle; start during busy -> no effect.
REQ-039 CCFF_LOADER_CRC_EN, 128-bit load of REQ-034 -> crc equals bench CRC-16-CCITT model; without the macro -> crc=0.
